// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds set-2 prefix bytes into key events, queues them,
// and exposes them through LC3-style KBSR/KBDR registers.
module ps2_kbd_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter bit          REPORT_BREAK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    input  logic        kbsr_wr,
    input  logic [15:0] wr_data,
    input  logic        kbdr_rd,
    output logic [15:0] kbsr,
    output logic [15:0] kbdr,
    output logic        irq,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e state_q, state_d;

    logic            is_ext, is_brk, is_prefix;
    logic            emit, emit_ext, emit_brk;
    logic            push_req, do_push, do_pop, full, empty;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [9:0]      mem [DEPTH];
    logic            ie_q, ovf_q, perr_q;
    logic            ovf_set, perr_set;
    logic [7:0]      err_cnt_q;
    logic            unused_wr;

    assign is_ext    = (rx_data == 8'hE0);
    assign is_brk    = (rx_data == 8'hF0);
    assign is_prefix = is_ext | is_brk;

    // Prefix FSM: state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix FSM: next state
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            if (rx_error || !is_prefix) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle:   state_d = is_ext ? StExt : StBrk;
                    StExt:    state_d = is_brk ? StExtBrk : StExt;
                    StBrk:    state_d = is_ext ? StExtBrk : StBrk;
                    default:  state_d = StExtBrk;
                endcase
            end
        end
    end

    // Prefix FSM: outputs
    always_comb begin
        emit     = rx_valid & ~rx_error & ~is_prefix;
        emit_ext = (state_q == StExt) || (state_q == StExtBrk);
        emit_brk = (state_q == StBrk) || (state_q == StExtBrk);
    end

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = emit & (REPORT_BREAK | ~emit_brk) & ~rst_n;
    assign do_pop   = kbdr_rd & ~empty & ~rst_n;
    // A pop on the same edge frees the slot a full FIFO needs.
    assign do_push  = push_req & (~full | do_pop);
    assign ovf_set  = push_req & full & ~do_pop;
    assign perr_set = rx_valid & rx_error;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= {emit_ext, emit_brk, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ie_q      <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
            if (kbsr_wr) begin
                ie_q <= wr_data[14];
            end
            // Set beats write-one-to-clear on the same edge.
            ovf_q  <= ovf_set  | (ovf_q  & ~(kbsr_wr & wr_data[13]));
            perr_q <= perr_set | (perr_q & ~(kbsr_wr & wr_data[12]));
            if (perr_set && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign kbsr      = {~empty, ie_q, ovf_q, perr_q, 12'h000};
    assign kbdr      = empty ? 16'h0000 : {6'b000000, mem[rd_ptr_q]};
    assign irq       = ie_q & ~empty;
    assign err_cnt   = err_cnt_q;
    assign unused_wr = ^{wr_data[15], wr_data[11:0]};

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized plus directed bench for ps2_kbd_ctrl; a queue-based reference model predicts
// register state and a monitor scoreboards every KBDR read.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam bit RB    = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n, rx_valid, rx_error, kbsr_wr, kbdr_rd;
    logic [7:0]  rx_data;
    logic [15:0] wr_data;
    logic [15:0] kbsr, kbdr, kbsr_b, kbdr_b;
    logic        irq, irq_b;
    logic [7:0]  err_cnt, err_cnt_b;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.DEPTH(DEPTH), .REPORT_BREAK(RB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .kbsr_wr(kbsr_wr), .wr_data(wr_data), .kbdr_rd(kbdr_rd),
        .kbsr(kbsr), .kbdr(kbdr), .irq(irq), .err_cnt(err_cnt)
    );

    // Second instance with break reporting disabled, fed the same stimulus.
    ps2_kbd_ctrl #(.DEPTH(DEPTH), .REPORT_BREAK(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_error(rx_error), .kbsr_wr(kbsr_wr), .wr_data(wr_data), .kbdr_rd(kbdr_rd),
        .kbsr(kbsr_b), .kbdr(kbdr_b), .irq(irq_b), .err_cnt(err_cnt_b)
    );

    int tests = 0;
    int fails = 0;

    logic [9:0]  m_q[$];
    logic [15:0] exp_q[$];
    bit          m_ext, m_brk, m_ie, m_ovf, m_perr;
    int          m_err;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefixes accumulate as two flags, FIFO is a bounded queue.
    task automatic model_step();
        logic [9:0] ev;
        bit push_req, pop, ovf_set, perr_set;
        ev = '0;
        push_req = 0;
        ovf_set = 0;
        perr_set = 0;
        if (rst_n) begin
            m_q.delete();
            m_ext = 0; m_brk = 0; m_ie = 0; m_ovf = 0; m_perr = 0; m_err = 0;
        end else begin
            pop = kbdr_rd && (m_q.size() > 0);
            if (rx_valid) begin
                if (rx_error) begin
                    perr_set = 1;
                    if (m_err < 255) m_err++;
                    m_ext = 0;
                    m_brk = 0;
                end else if (rx_data == 8'hE0) begin
                    m_ext = 1;
                end else if (rx_data == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    ev = {m_ext, m_brk, rx_data};
                    push_req = !m_brk || RB;
                    m_ext = 0;
                    m_brk = 0;
                end
            end
            if (pop) exp_q.push_back({6'b0, m_q.pop_front()});
            if (push_req) begin
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else ovf_set = 1;
            end
            if (kbsr_wr) begin
                m_ie = wr_data[14];
                if (wr_data[13]) m_ovf = 0;
                if (wr_data[12]) m_perr = 0;
            end
            if (ovf_set) m_ovf = 1;
            if (perr_set) m_perr = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        rst_n = 0; rx_valid = 0; rx_error = 0; kbsr_wr = 0; kbdr_rd = 0;
    endtask

    task automatic check_all(input string tag);
        bit rdy;
        rdy = m_q.size() > 0;
        check({tag, ".kbsr"}, kbsr, {rdy, m_ie, m_ovf, m_perr, 12'h000});
        check({tag, ".kbdr"}, kbdr, rdy ? {6'b0, m_q[0]} : 16'h0000);
        check({tag, ".irq"}, {15'b0, irq}, {15'b0, m_ie && rdy});
        check({tag, ".err_cnt"}, {8'b0, err_cnt}, m_err[15:0]);
    endtask

    task automatic send(input logic [7:0] b, input bit err);
        rx_valid = 1; rx_data = b; rx_error = err;
        cycle();
    endtask

    task automatic rd();
        kbdr_rd = 1;
        cycle();
    endtask

    task automatic wr(input logic [15:0] v);
        kbsr_wr = 1; wr_data = v;
        cycle();
    endtask

    task automatic reset();
        rst_n = 1;
        cycle();
    endtask

    // Scoreboard: every read of a non-empty FIFO must return the model's next event.
    always @(negedge clk) begin
        if (kbdr_rd && !rst_n && kbsr[15]) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL read_scoreboard: got %h expected no data", kbdr);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (kbdr !== e) begin
                    fails++;
                    $display("FAIL read_scoreboard: got %h expected %h", kbdr, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1; rx_valid = 0; rx_data = 0; rx_error = 0;
        kbsr_wr = 0; wr_data = 0; kbdr_rd = 0;
        cycle();
        check("reset.kbsr", kbsr, 16'h0000);
        check("reset.kbdr", kbdr, 16'h0000);
        check("reset.irq", {15'b0, irq}, 16'h0000);
        check("reset.err", {8'b0, err_cnt}, 16'h0000);

        send(8'h1C, 0);
        check("make.kbsr", kbsr, 16'h8000);
        check("make.kbdr", kbdr, 16'h001C);
        rd();
        check("pop.kbsr", kbsr, 16'h0000);
        check("pop.kbdr", kbdr, 16'h0000);

        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        check("extbrk.kbdr", kbdr, 16'h0375);
        rd();
        check("extbrk.single", kbsr, 16'h0000);

        reset();
        send(8'hF0, 0); send(8'h1C, 0);
        check("nobreak.kbsr", kbsr_b, 16'h0000);
        check("nobreak.kbdr", kbdr_b, 16'h0000);
        check("break.kbdr", kbdr, 16'h011C);
        send(8'h1C, 0);
        check("nobreak.make", kbdr_b, 16'h001C);
        check_all("mixed");

        reset();
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 0);
        check("ovf.kbsr", kbsr, 16'hA000);
        for (int i = 0; i < 4; i++) begin
            check("ovf.head", kbdr, 16'h0011 + 16'(i));
            rd();
        end
        check("ovf.drained", kbsr, 16'h2000);
        wr(16'h2000);
        check("ovf.clear", kbsr, 16'h0000);

        reset();
        send(8'hE0, 0); send(8'h55, 1); send(8'h74, 0);
        check("perr.kbdr", kbdr, 16'h0074);
        check("perr.kbsr", kbsr, 16'h9000);
        check("perr.cnt", {8'b0, err_cnt}, 16'h0001);
        for (int i = 0; i < 300; i++) send(8'(i), 1);
        check("perr.sat", {8'b0, err_cnt}, 16'h00FF);
        rd();
        check_all("perr");

        reset();
        wr(16'h4000);
        check("irq.empty", {15'b0, irq}, 16'h0000);
        send(8'h29, 0);
        check("irq.set", {15'b0, irq}, 16'h0001);
        rd();
        check("irq.clr", {15'b0, irq}, 16'h0000);
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 0);
        kbdr_rd = 1;
        send(8'h35, 0);
        check("fullrw.kbsr", kbsr, 16'hC000);
        check("fullrw.kbdr", kbdr, 16'h0032);
        for (int i = 0; i < 4; i++) rd();
        check("fullrw.drain", kbsr, 16'h4000);

        reset();
        send(8'h21, 0); send(8'h22, 0); send(8'hE0, 0);
        reset();
        check("midrst.kbsr", kbsr, 16'h0000);
        check("midrst.kbdr", kbdr, 16'h0000);
        check("midrst.irq", {15'b0, irq}, 16'h0000);
        check("midrst.err", {8'b0, err_cnt}, 16'h0000);
        send(8'h1C, 0);
        check("midrst.code", kbdr, 16'h001C);

        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom % 150) == 0;
            rx_valid = $urandom % 2;
            case ($urandom % 4)
                0:       rx_data = 8'hE0;
                1:       rx_data = 8'hF0;
                default: rx_data = 8'($urandom);
            endcase
            rx_error = ($urandom % 12) == 0;
            kbdr_rd  = ($urandom % 3) == 0;
            kbsr_wr  = ($urandom % 16) == 0;
            wr_data  = 16'($urandom);
            cycle();
            check_all("rand");
        end

        check("scoreboard.empty", 16'(exp_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Keyboard controller between the PS/2 host receiver and the LC3 memory-mapped I/O bus.
- Consumes received scan-code bytes, tracks set-2 prefix sequences (0xE0 extended, 0xF0 break) and assembles complete key events.
- Buffers key events in a small FIFO and presents them through LC3-style KBSR/KBDR registers with interrupt enable and sticky error flags.

Parameters:
- DEPTH, 4, number of key-event FIFO entries. Must be a power of 2, 2..16.
- REPORT_BREAK, 1, 1 = break (key release) events are queued; 0 = break events are decoded and silently discarded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous and active-high, despite the suffix.
- rx_valid  in  1  one-cycle strobe: a received byte is on rx_data/rx_error.
- rx_data  in  8  received scan-code byte, valid with rx_valid.
- rx_error  in  1  parity/framing error for this byte, valid with rx_valid.
- kbsr_wr  in  1  one-cycle write strobe to KBSR.
- wr_data  in  16  KBSR write data.
- kbdr_rd  in  1  one-cycle read strobe on KBDR; pops the FIFO head.
- kbsr  out  16  status register.
- kbdr  out  16  data register: FIFO head event.
- irq  out  1  interrupt request.
- err_cnt  out  8  saturating count of bytes received with rx_error.

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - While rst_n=1: prefix FSM goes to IDLE, FIFO empties, IE/OVF/PERR clear, err_cnt=0.
  - Reset values: kbsr=0x0000, kbdr=0x0000, irq=0, err_cnt=0.
  - Reset overrides all other inputs in the same cycle.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. Actions on rx_valid with rx_error=0:
  - IDLE: byte 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> emit {ext=0,brk=0,code} and stay in IDLE.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay in EXT; other -> emit {1,0,code}, go to IDLE.
  - BRK: 0xF0 -> stay; 0xE0 -> EXT_BRK; other -> emit {0,1,code}, go to IDLE.
  - EXT_BRK: 0xE0/0xF0 -> stay; other -> emit {1,1,code}, go to IDLE.
  - Prefix bytes are never queued. Any non-prefix byte (0xE1, 0xAA, 0xFA, ...) is an ordinary code.
- Byte with rx_error=1
  - Byte is discarded and the FSM returns to IDLE (pending prefix dropped).
  - PERR sets. err_cnt increments, saturating at 255.
- Emit with brk=1 and REPORT_BREAK=0: FSM updates as normal, nothing is pushed.
- Event format: kbdr = {6'b0, ext, brk, code[7:0]}.
- FIFO
  - Push occurs on the same edge that samples the final byte.
  - kbsr[15] and kbdr are valid the following cycle. Latency from rx_valid to visible event is 1 cycle.
  - kbdr shows the head entry and is 0x0000 when empty.
  - kbdr_rd pops on the edge it is sampled. kbdr_rd while empty is a no-op.
  - Push when full with no pop: event dropped, OVF sets, contents unchanged.
  - Push and pop together when full: both occur, no OVF.
  - Push and pop together when empty: push succeeds, pop ignored.
  - Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- KBSR
  - Layout: [15] RDY = FIFO non-empty (read-only); [14] IE (read/write); [13] OVF (sticky); [12] PERR (sticky); [11:0] = 0.
  - kbsr_wr: IE <= wr_data[14]. Writing 1 to bit 13 or 12 clears that flag; writing 0 leaves it.
  - A set event and a clear on the same edge resolve with set winning.
- irq = IE & RDY, combinational from registered state, no extra latency.
- err_cnt is not cleared by kbsr_wr; only reset clears it.

Test Plan:
- Reset, then bytes 0x1C -> kbsr=0x8000, kbdr=0x001C. kbdr_rd -> kbsr=0x0000, kbdr=0x0000.
- Sequence E0,F0,75 -> exactly one entry, kbdr=0x0375. Sequence F0,1C with REPORT_BREAK=0 -> FIFO stays empty.
- DEPTH=4: push 5 events 0x11..0x15 with no reads -> kbsr=0xA000. Reads return 0x11..0x14, then kbsr=0x2000. Write 0x2000 -> OVF clears to 0x0000.
- E0 then a byte with rx_error=1, then 0x74 -> kbdr=0x0074, kbsr[12]=1, err_cnt=1. Additionally, 300 error bytes -> err_cnt=255.
- kbsr_wr 0x4000 with FIFO empty -> irq=0. Push 0x29 -> irq=1 one cycle after rx_valid. kbdr_rd -> irq=0. FIFO full with rx_valid and kbdr_rd on the same edge -> count unchanged, OVF=0.
- Assert rst_n mid-prefix (after E0) with 2 entries queued -> all outputs 0. Then byte 0x1C -> kbdr=0x001C (no ext bit).
